// File: rtl/mem_access_unit.sv
// mem_access_unit: bridges controller load/store requests to a word-only,
// little-endian memory. Sub-word stores are read-modify-write, loads are
// extended, misaligned requests are rejected without touching memory.
//
// state | meaning
// IDLE  | waiting for req; latches the request on acceptance
// RD    | mem_mrd high; read word captured on the edge leaving RD
// WR    | mem_mwr high; merged word written on the edge leaving WR
// DONE  | done pulse; err qualifies it for rejected requests
module mem_access_unit #(
    parameter int unsigned ADDR_W      = 32,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       rdata_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [31:0]       mem_d_in_o,
    output logic              mem_mrd_o,
    output logic              mem_mwr_o,
    input  logic [31:0]       mem_d_out_i
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                sign_q, sign_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [31:0]         merge_q, merge_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                misalign;
    logic [1:0]          lane;
    logic [31:0]         rd_shift;
    logic [15:0]         rd_half;
    logic [31:0]         load_ext;
    logic [31:0]         merged;

    // State and latched request registers, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
        end
    end

    // Alignment check on the incoming request; reserved size always rejects
    always_comb begin
        misalign = (size_i == SZ_RSVD);
        if (ALIGN_CHECK) begin
            if (size_i == SZ_HALF && addr_i[0])
                misalign = 1'b1;
            if (size_i == SZ_WORD && addr_i[1:0] != 2'b00)
                misalign = 1'b1;
        end
    end

    // Effective lane; without the check, half/word lane bits are dropped
    always_comb begin
        lane = addr_q[1:0];
        if (!ALIGN_CHECK) begin
            if (size_q == SZ_HALF) lane[0] = 1'b0;
            if (size_q == SZ_WORD) lane    = 2'b00;
        end
    end

    // Load extraction and extension from the combinational memory read
    always_comb begin
        rd_shift = mem_d_out_i >> {lane, 3'b000};
        rd_half  = lane[1] ? mem_d_out_i[31:16] : mem_d_out_i[15:0];
        case (size_q)
            SZ_BYTE: load_ext = {{24{sign_q & rd_shift[7]}}, rd_shift[7:0]};
            SZ_HALF: load_ext = {{16{sign_q & rd_half[15]}}, rd_half};
            default: load_ext = mem_d_out_i;
        endcase
    end

    // Store word: replace only the addressed lanes of the read-back word
    always_comb begin
        merged = merge_q;
        case (size_q)
            SZ_BYTE: merged[{lane, 3'b000} +: 8]        = wdata_q[7:0];
            SZ_HALF: merged[{lane[1], 4'b0000} +: 16]   = wdata_q[15:0];
            default: merged                              = wdata_q;
        endcase
    end

    // Next-state logic and request/result capture
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    we_d    = we_i;
                    size_d  = size_i;
                    sign_d  = sign_ext_i;
                    wdata_d = wdata_i;
                    err_d   = misalign;
                    if (misalign)
                        state_d = S_DONE;
                    else if (we_i && size_i == SZ_WORD)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                if (we_q) begin
                    merge_d = mem_d_out_i;
                    state_d = S_WR;
                end else begin
                    rdata_d = load_ext;
                    state_d = S_DONE;
                end
            end
            S_WR:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status and memory-side outputs decoded from the state register only
    always_comb begin
        busy_o     = (state_q != S_IDLE);
        done_o     = (state_q == S_DONE);
        err_o      = (state_q == S_DONE) && err_q;
        rdata_o    = rdata_q;
        mem_adr_o  = '0;
        mem_d_in_o = '0;
        mem_mrd_o  = 1'b0;
        mem_mwr_o  = 1'b0;
        case (state_q)
            S_RD: begin
                mem_mrd_o = 1'b1;
                mem_adr_o = {addr_q[ADDR_W-1:2], 2'b00};
            end
            S_WR: begin
                mem_mwr_o  = 1'b1;
                mem_adr_o  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_d_in_o = merged;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: fixed vector table, randomized ops against a
// mask/shift reference model, and hand sequences for hold/reset corners.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic [31:0] mem_adr;
    logic [31:0] mem_d_in;
    logic        mem_mrd, mem_mwr;
    logic [31:0] mem_d_out;

    mem_access_unit #(.ADDR_W(32), .ALIGN_CHECK(1'b1)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_i      (req),
        .we_i       (we),
        .size_i     (size),
        .sign_ext_i (sign_ext),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .rdata_o    (rdata),
        .mem_adr_o  (mem_adr),
        .mem_d_in_o (mem_d_in),
        .mem_mrd_o  (mem_mrd),
        .mem_mwr_o  (mem_mwr),
        .mem_d_out_i(mem_d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory attached to the DUT: combinational read, write on posedge
    logic [31:0] tb_mem [1024];
    assign mem_d_out = tb_mem[mem_adr[11:2]];
    always @(posedge clk) if (mem_mwr) tb_mem[mem_adr[11:2]] <= mem_d_in;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [1024];
    logic [31:0] ref_rdata;

    typedef struct {
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] din;
        logic [31:0] rdata;
    } exp_t;

    task automatic ref_apply(input logic t_we, input logic [1:0] t_sz, input logic t_sg,
                             input logic [31:0] t_ad, input logic [31:0] t_wd, output exp_t e);
        int          sh;
        int          idx;
        logic [31:0] w, v, mask;
        sh  = 8 * int'(t_ad[1:0]);
        idx = int'(t_ad[11:2]);
        w   = ref_mem[idx];
        e.err = (t_sz == 2'd3) || (t_sz == 2'd1 && t_ad[0]) || (t_sz == 2'd2 && t_ad[1:0] != 2'd0);
        e.din = 32'h0;
        if (e.err) begin
            e.lat = 1; e.nrd = 0; e.nwr = 0;
        end else if (!t_we) begin
            v = w >> sh;
            if (t_sz == 2'd0) begin
                v = v & 32'hFF;
                if (t_sg && v >= 32'h80) v = v | 32'hFFFFFF00;
            end else if (t_sz == 2'd1) begin
                v = v & 32'hFFFF;
                if (t_sg && v >= 32'h8000) v = v | 32'hFFFF0000;
            end else begin
                v = w;
            end
            ref_rdata = v;
            e.lat = 2; e.nrd = 1; e.nwr = 0;
        end else begin
            mask = (t_sz == 2'd0) ? 32'hFF : (t_sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
            v = (w & ~(mask << sh)) | ((t_wd & mask) << sh);
            ref_mem[idx] = v;
            e.din = v;
            e.nwr = 1;
            e.nrd = (t_sz == 2'd2) ? 0 : 1;
            e.lat = (t_sz == 2'd2) ? 2 : 3;
        end
        e.rdata = ref_rdata;
    endtask

    // Observations from one operation
    int          obs_lat, obs_nrd, obs_nwr, obs_bad;
    logic        obs_err;
    logic [31:0] obs_din, obs_rdata;

    task automatic run_op(input logic t_we, input logic [1:0] t_sz, input logic t_sg,
                          input logic [31:0] t_ad, input logic [31:0] t_wd);
        bit seen;
        @(negedge clk);
        req = 1'b1; we = t_we; size = t_sz; sign_ext = t_sg; addr = t_ad; wdata = t_wd;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        obs_lat = 0; obs_nrd = 0; obs_nwr = 0; obs_bad = 0;
        obs_err = 1'b0; obs_din = 32'h0; obs_rdata = 32'h0; seen = 1'b0;
        for (int cyc = 1; cyc <= 8 && !seen; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (mem_mrd) begin
                obs_nrd++;
                if (mem_adr != {t_ad[31:2], 2'b00}) obs_bad++;
            end
            if (mem_mwr) begin
                obs_nwr++;
                obs_din = mem_d_in;
                if (mem_adr != {t_ad[31:2], 2'b00}) obs_bad++;
            end
            if (!mem_mrd && !mem_mwr && (mem_adr != 32'h0 || mem_d_in != 32'h0)) obs_bad++;
            if (done) begin
                seen = 1'b1; obs_lat = cyc; obs_err = err; obs_rdata = rdata;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_nrd;
        int          exp_nwr;
        logic [31:0] exp_din;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt [10];
    exp_t e;

    initial begin
        vt[0] = '{1'b1, 2'd2, 1'b0, 32'h3E8, 32'h8899AABB, 1'b0, 2, 0, 1, 32'h8899AABB, 32'h0};
        vt[1] = '{1'b0, 2'd0, 1'b1, 32'h3E8, 32'h0,        1'b0, 2, 1, 0, 32'h0,        32'hFFFFFFBB};
        vt[2] = '{1'b0, 2'd0, 1'b0, 32'h3E8, 32'h0,        1'b0, 2, 1, 0, 32'h0,        32'h000000BB};
        vt[3] = '{1'b0, 2'd1, 1'b1, 32'h3EA, 32'h0,        1'b0, 2, 1, 0, 32'h0,        32'hFFFF8899};
        vt[4] = '{1'b0, 2'd1, 1'b0, 32'h3EA, 32'h0,        1'b0, 2, 1, 0, 32'h0,        32'h00008899};
        vt[5] = '{1'b1, 2'd0, 1'b0, 32'h3E9, 32'h00000055, 1'b0, 3, 1, 1, 32'h889955BB, 32'h00008899};
        vt[6] = '{1'b0, 2'd2, 1'b0, 32'h3E8, 32'h0,        1'b0, 2, 1, 0, 32'h0,        32'h889955BB};
        vt[7] = '{1'b0, 2'd2, 1'b0, 32'h3EA, 32'h0,        1'b1, 1, 0, 0, 32'h0,        32'h889955BB};
        vt[8] = '{1'b1, 2'd1, 1'b0, 32'h3E9, 32'h1234,     1'b1, 1, 0, 0, 32'h0,        32'h889955BB};
        vt[9] = '{1'b0, 2'd3, 1'b0, 32'h3E8, 32'h0,        1'b1, 1, 0, 0, 32'h0,        32'h889955BB};

        for (int i = 0; i < 1024; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        ref_rdata = 32'h0;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_status", {27'h0, busy, done, err, mem_mrd, mem_mwr}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_mem_adr", mem_adr, 32'h0);
        chk("reset_mem_d_in", mem_d_in, 32'h0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            ref_apply(vt[i].we, vt[i].size, vt[i].sign, vt[i].addr, vt[i].wdata, e);
            run_op(vt[i].we, vt[i].size, vt[i].sign, vt[i].addr, vt[i].wdata);
            chk($sformatf("tbl%0d_err", i), {31'h0, obs_err}, {31'h0, vt[i].exp_err});
            chk($sformatf("tbl%0d_latency", i), obs_lat, vt[i].exp_lat);
            chk($sformatf("tbl%0d_nrd", i), obs_nrd, vt[i].exp_nrd);
            chk($sformatf("tbl%0d_nwr", i), obs_nwr, vt[i].exp_nwr);
            chk($sformatf("tbl%0d_memside", i), obs_bad, 0);
            if (vt[i].exp_nwr != 0) chk($sformatf("tbl%0d_d_in", i), obs_din, vt[i].exp_din);
            chk($sformatf("tbl%0d_rdata", i), obs_rdata, vt[i].exp_rdata);
        end
        chk("tbl_mem_word", tb_mem[32'h3E8 >> 2], 32'h889955BB);

        // Randomized ops against the reference model
        for (int i = 0; i < 200; i++) begin
            logic        r_we, r_sg;
            logic [1:0]  r_sz;
            logic [31:0] r_ad, r_wd;
            r_we = 1'($urandom_range(0, 1));
            r_sg = 1'($urandom_range(0, 1));
            r_sz = 2'($urandom_range(0, 3));
            r_ad = $urandom_range(0, 1023);
            r_wd = $urandom;
            ref_apply(r_we, r_sz, r_sg, r_ad, r_wd, e);
            run_op(r_we, r_sz, r_sg, r_ad, r_wd);
            chk($sformatf("rnd%0d_err", i), {31'h0, obs_err}, {31'h0, e.err});
            chk($sformatf("rnd%0d_latency", i), obs_lat, e.lat);
            chk($sformatf("rnd%0d_access", i), {obs_nrd[15:0], obs_nwr[15:0]}, {e.nrd[15:0], e.nwr[15:0]});
            chk($sformatf("rnd%0d_memside", i), obs_bad, 0);
            chk($sformatf("rnd%0d_rdata", i), obs_rdata, e.rdata);
            if (e.nwr != 0) begin
                chk($sformatf("rnd%0d_d_in", i), obs_din, e.din);
                chk($sformatf("rnd%0d_mem", i), tb_mem[r_ad[11:2]], ref_mem[r_ad[11:2]]);
            end
        end

        // req held high across a sub-word store, then a load queued behind it
        begin
            int  nrd, nwr;
            bit  seen;
            exp_t e2;
            ref_apply(1'b1, 2'd0, 1'b0, 32'h105, 32'h5A, e);
            @(negedge clk);
            req = 1'b1; we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h105; wdata = 32'h5A;
            @(posedge clk);
            nrd = 0; nwr = 0; seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                @(negedge clk);
                if (mem_mrd) nrd++;
                if (mem_mwr) nwr++;
                if (done) seen = 1'b1;
            end
            chk("hold_reads", nrd, 1);
            chk("hold_writes", nwr, 1);
            we = 1'b0; sign_ext = 1'b1;
            @(negedge clk);
            chk("hold_idle_after_done", {31'h0, busy}, 32'h0);
            @(negedge clk);
            chk("hold_next_accept", {30'h0, busy, mem_mrd}, 32'h3);
            req = 1'b0;
            ref_apply(1'b0, 2'd0, 1'b1, 32'h105, 32'h0, e2);
            @(negedge clk);
            chk("hold_load_done", {31'h0, done}, 32'h1);
            chk("hold_load_rdata", rdata, e2.rdata);
        end

        // Reset during RD of a byte store: nothing written
        begin
            int nwr;
            nwr = 0;
            @(negedge clk);
            req = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h201; wdata = 32'hEE;
            @(posedge clk);
            @(negedge clk);
            req = 1'b0;
            chk("rstrd_in_rd", {31'h0, mem_mrd}, 32'h1);
            if (mem_mwr) nwr++;
            rst_n = 1'b0;
            @(negedge clk);
            if (mem_mwr) nwr++;
            rst_n = 1'b1;
            ref_rdata = 32'h0;
            chk("rstrd_outputs", {27'h0, busy, done, err, mem_mrd, mem_mwr}, 32'h0);
            chk("rstrd_rdata", rdata, 32'h0);
            chk("rstrd_mem_adr", mem_adr, 32'h0);
            chk("rstrd_mem_d_in", mem_d_in, 32'h0);
            @(negedge clk);
            if (mem_mwr) nwr++;
            chk("rstrd_no_write", nwr, 0);
            chk("rstrd_mem_word", tb_mem[32'h201 >> 2], ref_mem[32'h201 >> 2]);
        end

        // Reset during WR of a word store: the write still commits
        begin
            @(negedge clk);
            req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h300; wdata = 32'h12345678;
            @(posedge clk);
            @(negedge clk);
            req = 1'b0;
            chk("rstwr_in_wr", {31'h0, mem_mwr}, 32'h1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            ref_mem[32'h300 >> 2] = 32'h12345678;
            chk("rstwr_committed", tb_mem[32'h300 >> 2], 32'h12345678);
            chk("rstwr_idle", {30'h0, busy, done}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
